// File: rtl/ysyx_23060236_btb_ctrl.sv
// EXU-side BTB sequencer: checks resolved branches against the BTB prediction,
// redirects IFU on a mispredict and queues corrective BTB writes.
module ysyx_23060236_btb_ctrl #(
    parameter int ADDR_LEN   = 32,
    parameter int UPDQ_DEPTH = 2,
    parameter int CNT_LEN    = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                exu_valid,
    output logic                exu_ready,
    input  logic [ADDR_LEN-1:0] exu_pc,
    input  logic [ADDR_LEN-1:0] exu_npc,
    output logic [ADDR_LEN-1:0] btb_araddr_exu,
    input  logic [ADDR_LEN-1:0] btb_rdata_exu,
    output logic                redirect_valid,
    input  logic                redirect_ready,
    output logic [ADDR_LEN-1:0] redirect_pc,
    output logic                btb_wvalid,
    output logic [ADDR_LEN-1:0] btb_awaddr,
    output logic [ADDR_LEN-1:0] btb_wdata,
    output logic [CNT_LEN-1:0]  perf_resolved,
    output logic [CNT_LEN-1:0]  perf_mispred
);

    localparam int PW = $clog2(UPDQ_DEPTH);

    typedef enum logic {IDLE, REDIR} state_t;

    state_t              state_q, state_d;
    logic [ADDR_LEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [CNT_LEN-1:0]  resolved_q, resolved_d;
    logic [CNT_LEN-1:0]  mispred_q, mispred_d;
    logic [PW:0]         wr_ptr_q, wr_ptr_d;
    logic [PW:0]         rd_ptr_q, rd_ptr_d;
    logic [ADDR_LEN-1:0] q_pc   [UPDQ_DEPTH];
    logic [ADDR_LEN-1:0] q_npc  [UPDQ_DEPTH];

    logic fifo_empty, fifo_full, xfer, mispredict, push, pop;

    // The extra wrap bit tells full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

    assign exu_ready      = (state_q == IDLE) && !fifo_full;
    assign btb_araddr_exu = exu_pc;
    assign xfer           = exu_valid && exu_ready;
    assign mispredict     = (btb_rdata_exu != exu_npc);
    assign push           = xfer && mispredict;
    assign pop            = !fifo_empty;

    assign redirect_valid = (state_q == REDIR);
    assign redirect_pc    = redirect_pc_q;
    assign btb_wvalid     = pop;
    assign btb_awaddr     = q_pc[rd_ptr_q[PW-1:0]];
    assign btb_wdata      = q_npc[rd_ptr_q[PW-1:0]];
    assign perf_resolved  = resolved_q;
    assign perf_mispred   = mispred_q;

    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        resolved_d    = resolved_q;
        mispred_d     = mispred_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;

        case (state_q)
            IDLE: begin
                if (push) begin
                    state_d       = REDIR;
                    redirect_pc_d = exu_npc;
                end
            end
            REDIR: begin
                if (redirect_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (xfer) resolved_d = resolved_q + CNT_LEN'(1);
        if (push) begin
            mispred_d = mispred_q + CNT_LEN'(1);
            wr_ptr_d  = wr_ptr_q + (PW+1)'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + (PW+1)'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            redirect_pc_q <= '0;
            resolved_q    <= '0;
            mispred_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            resolved_q    <= resolved_d;
            mispred_q     <= mispred_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            q_pc[wr_ptr_q[PW-1:0]]  <= exu_pc;
            q_npc[wr_ptr_q[PW-1:0]] <= exu_npc;
        end
    end

endmodule
